// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK control with
// fetch timeout, illegal-opcode and ECALL halting, and a saturating retired-instruction counter.
module core_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        alu_en,
    output logic        rf_we,
    output logic        halted,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [31:0] ECALL_WORD   = 32'h0000_0073;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic [1:0]  r_fault;
    logic [7:0]  r_tcnt;

    logic w_legal;
    assign w_legal = (r_instr[6:0] == 7'b0110011) || (r_instr[6:0] == 7'b0010011);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0;
            r_retired <= 32'h0;
            r_fault   <= 2'b00;
            r_tcnt    <= 8'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                        r_tcnt  <= 8'h0;
                    end
                end
                S_FETCH: begin
                    // An ack on the last permitted cycle still wins over the timeout.
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= S_DECODE;
                    end else if (r_tcnt == TIMEOUT_LAST) begin
                        r_state <= S_HALT;
                        r_fault <= 2'b10;
                    end else begin
                        r_tcnt <= r_tcnt + 8'h1;
                    end
                end
                S_DECODE: begin
                    if (r_instr == ECALL_WORD) begin
                        r_state <= S_HALT;
                    end else if (w_legal) begin
                        r_state <= S_EXECUTE;
                    end else begin
                        r_state <= S_HALT;
                        r_fault <= 2'b01;
                    end
                end
                S_EXECUTE: begin
                    r_state <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    r_pc <= r_pc + 32'd4;
                    if (r_retired != 32'hFFFF_FFFF) begin
                        r_retired <= r_retired + 32'd1;
                    end
                    if (run) begin
                        r_state <= S_FETCH;
                        r_tcnt  <= 8'h0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign instr      = r_instr;
    assign alu_en     = (r_state == S_EXECUTE);
    assign rf_we      = (r_state == S_WRITEBACK) && (r_instr[11:7] != 5'd0);
    assign halted     = (r_state == S_HALT);
    assign fault_code = r_fault;
    assign retired    = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios plus a randomized
// instruction stream checked against a per-instruction behavioural model.
module tb_core_sequencer;

    localparam logic [31:0] RPC = 32'hFFFF_FFFC;
    localparam int          TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        alu_en;
    logic        rf_we;
    logic        halted;
    logic [1:0]  fault_code;
    logic [31:0] retired;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    core_sequencer #(
        .RESET_PC     (RPC),
        .FETCH_TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .instr     (instr),
        .alu_en    (alu_en),
        .rf_we     (rf_we),
        .halted    (halted),
        .fault_code(fault_code),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // 0 = legal ALU op, 1 = ECALL, 2 = illegal
    function automatic int classify(input logic [31:0] w);
        if (w == 32'h0000_0073) return 1;
        if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) return 0;
        return 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        run = 1'b0; imem_ack = 1'b0;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({imem_req, alu_en, rf_we, halted} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL %s_rst_ctrl got=%b want=0000", tag, {imem_req, alu_en, rf_we, halted});
        end
        tests_run++;
        if (fault_code !== 2'b00 || retired !== 32'h0 || instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL %s_rst_regs got fault=%b ret=%h instr=%h want 0", tag, fault_code, retired, instr);
        end
        tests_run++;
        if (imem_addr !== RPC) begin
            tests_failed++;
            $display("FAIL %s_rst_pc got=%h want=%h", tag, imem_addr, RPC);
        end
        step();
        reset = 1'b0;
        exp_pc = RPC; exp_ret = 32'h0;
        step();
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle_hold got=%b want=0", tag, imem_req);
        end
        $display("[TB] reset %s", tag);
    endtask

    task automatic start_run();
        run = 1'b1;
        step();
        tests_run++;
        if (imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_fetch got=%b want=1", imem_req);
        end
    endtask

    // Entered in FETCH; drives one instruction through and checks every phase.
    task automatic run_instr(input logic [31:0] w, input int waits, input bit keep_run);
        int kind;
        kind = classify(w);
        for (int c = 0; c <= waits; c++) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
                tests_failed++;
                $display("FAIL fetch_cyc%0d got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, exp_pc);
            end
            imem_ack   = (c == waits);
            imem_rdata = (c == waits) ? w : $urandom;
            step();
        end
        tests_run++;
        if (imem_req !== 1'b0 || instr !== w || alu_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL decode got req=%b instr=%h alu=%b want req=0 instr=%h alu=0", imem_req, instr, alu_en, w);
        end
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        step();
        if (kind != 0) begin
            imem_ack = 1'b0;
            tests_run++;
            if (halted !== 1'b1 || fault_code !== ((kind == 1) ? 2'b00 : 2'b01)) begin
                tests_failed++;
                $display("FAIL halt_decode got halted=%b fault=%b want halted=1 fault=%b", halted, fault_code, (kind == 1) ? 2'b00 : 2'b01);
            end
            tests_run++;
            if (retired !== exp_ret || imem_addr !== exp_pc || imem_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL halt_state got ret=%h addr=%h req=%b want ret=%h addr=%h req=0", retired, imem_addr, imem_req, exp_ret, exp_pc);
            end
            $display("[TB] instr %h pc=%h waits=%0d -> halt kind=%0d", w, exp_pc, waits, kind);
            return;
        end
        tests_run++;
        if (alu_en !== 1'b1 || rf_we !== 1'b0 || halted !== 1'b0 || instr !== w) begin
            tests_failed++;
            $display("FAIL execute got alu=%b we=%b halted=%b instr=%h want 1/0/0/%h", alu_en, rf_we, halted, instr, w);
        end
        run = keep_run;
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        step();
        tests_run++;
        if (alu_en !== 1'b0 || rf_we !== (w[11:7] != 5'd0) || imem_req !== 1'b0 || retired !== exp_ret) begin
            tests_failed++;
            $display("FAIL writeback got alu=%b we=%b req=%b ret=%h want 0/%b/0/%h", alu_en, rf_we, imem_req, retired, w[11:7] != 5'd0, exp_ret);
        end
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        step();
        imem_ack = 1'b0;
        exp_pc = exp_pc + 32'd4;
        if (exp_ret != 32'hFFFF_FFFF) exp_ret = exp_ret + 32'd1;
        tests_run++;
        if (retired !== exp_ret || imem_addr !== exp_pc || instr !== w) begin
            tests_failed++;
            $display("FAIL retire got ret=%h addr=%h instr=%h want ret=%h addr=%h instr=%h", retired, imem_addr, instr, exp_ret, exp_pc, w);
        end
        tests_run++;
        if (imem_req !== keep_run || rf_we !== 1'b0 || alu_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_wb got req=%b we=%b alu=%b want req=%b we=0 alu=0", imem_req, rf_we, alu_en, keep_run);
        end
        $display("[TB] instr %h waits=%0d run=%0b -> retired=%0d pc=%h", w, waits, keep_run, exp_ret, exp_pc);
    endtask

    task automatic test_halt_hold(input logic [1:0] want_fault);
        for (int c = 0; c < 4; c++) begin
            run = 1'($urandom_range(0, 1)); imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            step();
            tests_run++;
            if (halted !== 1'b1 || fault_code !== want_fault || imem_req !== 1'b0 || imem_addr !== exp_pc || retired !== exp_ret) begin
                tests_failed++;
                $display("FAIL halt_hold got halted=%b fault=%b req=%b addr=%h ret=%h want 1/%b/0/%h/%h", halted, fault_code, imem_req, imem_addr, retired, want_fault, exp_pc, exp_ret);
            end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        clk = 1'b0;
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        apply_reset("initial");
        run = 1'b0;
        step();
        tests_run++;
        if (imem_req !== 1'b0 || halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_run got req=%b halted=%b want 0/0", imem_req, halted);
        end
    endtask

    task automatic test_zero_wait();
        start_run();
        run_instr(32'h003100B3, 0, 1'b1);
        run_instr(32'h0000_0073, 0, 1'b1);
        test_halt_hold(2'b00);
        apply_reset("after_ecall");
    endtask

    task automatic test_wait_states_and_x0();
        start_run();
        run_instr(32'h0020_81B3, 3, 1'b1);
        run_instr(32'h0010_0013, 0, 1'b0);
        step();
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== exp_pc || retired !== exp_ret) begin
            tests_failed++;
            $display("FAIL idle_stop got req=%b addr=%h ret=%h want 0/%h/%h", imem_req, imem_addr, retired, exp_pc, exp_ret);
        end
        start_run();
        run_instr(32'h0000_0000, 0, 1'b1);
        test_halt_hold(2'b01);
        apply_reset("after_illegal");
    endtask

    task automatic test_timeout();
        start_run();
        imem_ack = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            tests_run++;
            if (imem_req !== 1'b1 || halted !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_cyc%0d got req=%b halted=%b want 1/0", c, imem_req, halted);
            end
            step();
        end
        tests_run++;
        if (halted !== 1'b1 || fault_code !== 2'b10 || imem_req !== 1'b0 || retired !== 32'h0 || imem_addr !== exp_pc) begin
            tests_failed++;
            $display("FAIL timeout_halt got halted=%b fault=%b req=%b ret=%h addr=%h want 1/10/0/0/%h", halted, fault_code, imem_req, retired, imem_addr, exp_pc);
        end
        $display("[TB] fetch timeout after %0d cycles", TMO);
        test_halt_hold(2'b10);
        apply_reset("after_timeout");
    endtask

    task automatic test_async_reset();
        start_run();
        imem_ack = 1'b1; imem_rdata = 32'h0050_0293;
        step();
        imem_ack = 1'b0;
        step();
        step();
        tests_run++;
        if (rf_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre_wb got we=%b want 1", rf_we);
        end
        #2 reset = 1'b1; run = 1'b0;
        #1;
        tests_run++;
        if ({imem_req, alu_en, rf_we, halted} !== 4'b0000 || retired !== 32'h0 || instr !== 32'h0 || imem_addr !== RPC || fault_code !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset got ctrl=%b ret=%h instr=%h addr=%h fault=%b want 0000/0/0/%h/00", {imem_req, alu_en, rf_we, halted}, retired, instr, imem_addr, RPC, fault_code);
        end
        reset = 1'b0;
        exp_pc = RPC; exp_ret = 32'h0;
        step();
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== RPC) begin
            tests_failed++;
            $display("FAIL async_resume_idle got req=%b addr=%h want 0/%h", imem_req, imem_addr, RPC);
        end
        $display("[TB] async reset during writeback");
    endtask

    task automatic test_random();
        logic [31:0] w;
        int          r, waits, kind;
        bit          keep;
        start_run();
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 11);
            w = $urandom;
            if (r == 0) begin
                w = 32'h0000_0073;
            end else if (r == 1) begin
                w[6:0] = 7'b0000011;
            end else begin
                w[6:0] = r[0] ? 7'b0110011 : 7'b0010011;
                if (r == 2) w[11:7] = 5'd0;
            end
            waits = ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 4);
            keep  = ($urandom_range(0, 3) != 0);
            kind  = classify(w);
            run_instr(w, waits, keep);
            if (kind != 0) begin
                test_halt_hold((kind == 1) ? 2'b00 : 2'b01);
                apply_reset("random_halt");
                start_run();
            end else if (!keep) begin
                start_run();
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states_and_x0();
        test_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
